// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment opcode display.
// Includes the opcode code points and a width helper for counters and anode indices.
package seg7_pkg;

  localparam logic [3:0] DASH_CODE = 4'hF;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_ORR = 4'd4,
    OP_CMP = 4'd5,
    OP_MVN = 4'd6,
    OP_LDR = 4'd7,
    OP_STR = 4'd8,
    OP_B   = 4'd9,
    OP_BX  = 4'd10
  } opcode_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
// o_cnt_nxt is the count the next edge will load, letting the parent register its outputs.
module seg7_tick_gen
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  localparam int CW = idx_w(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_wrap    = (r_cnt == LAST_CNT);
  assign o_cnt_nxt = o_wrap ? '0 : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed digit scanner with per-slot blanking and a frame-aligned shadow buffer.
// Outputs are registered from next-state values so each one matches the slot it is shown in.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   codes_i,
  input  logic [N_DIGITS-1:0]     en_mask_i,
  output logic [3:0]              code_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    blank_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int CW = idx_w(REFRESH_DIV);
  localparam int DW = idx_w(N_DIGITS);
  localparam logic [DW-1:0] LAST_DIG  = DW'(N_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic          BLANK_RST = (BLANK_CYC > 0);

  logic [CW-1:0]              w_cnt_nxt;
  logic                       w_wrap;
  logic                       w_frame_wrap;
  logic                       w_xfer;
  logic [DW-1:0]              w_dig_nxt;
  logic [N_DIGITS-1:0][3:0]   w_act_nxt;
  logic [N_DIGITS-1:0]        w_msk_nxt;
  logic                       w_blank_nxt;
  logic [N_DIGITS-1:0]        w_an_nxt;

  logic [DW-1:0]              r_dig;
  logic [N_DIGITS-1:0][3:0]   r_act;
  logic [N_DIGITS-1:0]        r_act_msk;
  logic [N_DIGITS-1:0][3:0]   r_shd;
  logic [N_DIGITS-1:0]        r_shd_msk;
  logic                       r_pend;
  logic [3:0]                 r_code;
  logic [N_DIGITS-1:0]        r_an;
  logic                       r_blank;
  logic                       r_frame;

  seg7_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .o_cnt_nxt (w_cnt_nxt),
    .o_wrap    (w_wrap)
  );

  assign w_frame_wrap = w_wrap && (r_dig == LAST_DIG);
  assign w_dig_nxt    = !w_wrap ? r_dig : (w_frame_wrap ? '0 : r_dig + 1'b1);

  // Transfer reads the shadow as held before this edge; a same-cycle load lands afterwards.
  assign w_xfer      = w_frame_wrap && r_pend;
  assign w_act_nxt   = w_xfer ? r_shd     : r_act;
  assign w_msk_nxt   = w_xfer ? r_shd_msk : r_act_msk;
  assign w_blank_nxt = (w_cnt_nxt < BLANK_END);

  always_comb begin
    w_an_nxt = '1;
    if (!w_blank_nxt && w_msk_nxt[w_dig_nxt]) begin
      w_an_nxt[w_dig_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig     <= '0;
      r_act     <= {N_DIGITS{DASH_CODE}};
      r_act_msk <= '1;
      r_shd     <= {N_DIGITS{DASH_CODE}};
      r_shd_msk <= '1;
      r_pend    <= 1'b0;
      r_code    <= DASH_CODE;
      r_an      <= '1;
      r_blank   <= BLANK_RST;
      r_frame   <= 1'b0;
    end else begin
      r_dig     <= w_dig_nxt;
      r_act     <= w_act_nxt;
      r_act_msk <= w_msk_nxt;
      if (load_i) begin
        r_shd     <= codes_i;
        r_shd_msk <= en_mask_i;
        r_pend    <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pend    <= 1'b0;
      end
      r_code    <= w_act_nxt[w_dig_nxt];
      r_an      <= w_an_nxt;
      r_blank   <= w_blank_nxt;
      r_frame   <= w_frame_wrap;
    end
  end

  assign code_o    = r_code;
  assign an_o      = r_an;
  assign blank_o   = r_blank;
  assign frame_o   = r_frame;
  assign pending_o = r_pend;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
// The driver pushes per-cycle expectations from a small behavioural model; a monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        load_i    = 1'b0;
  logic [15:0] codes_i   = 16'h0;
  logic [3:0]  en_mask_i = 4'h0;
  logic [3:0]  code_o;
  logic [3:0]  an_o;
  logic        blank_o;
  logic        frame_o;
  logic        pending_o;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] an;
    logic       blank;
    logic       frame;
    logic       pend;
    int         t;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model state: t is the cycle index since the last reset cycle (reset cycle is t=0).
  int          t      = 0;
  logic [15:0] m_act  = 16'hFFFF;
  logic [15:0] m_shd  = 16'hFFFF;
  logic [3:0]  m_msk  = 4'hF;
  logic [3:0]  m_shm  = 4'hF;
  logic        m_pend = 1'b0;
  logic        p_rst  = 1'b1;
  logic        p_ld   = 1'b0;
  logic [15:0] p_c    = 16'h0;
  logic [3:0]  p_m    = 4'h0;

  seg7_scan_ctrl #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_i),
    .codes_i   (codes_i),
    .en_mask_i (en_mask_i),
    .code_o    (code_o),
    .an_o      (an_o),
    .blank_o   (blank_o),
    .frame_o   (frame_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tt, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0d: got %h, expected %h", nm, tt, got, exp);
  endtask

  // Advance one cycle: apply the previous cycle's inputs to the model, queue the
  // expectation for the cycle now starting, then drive this cycle's inputs.
  task automatic step(input logic r, input logic ld, input logic [15:0] c, input logic [3:0] m);
    int   cnt;
    int   dig;
    exp_t e;
    @(posedge clk);
    #1;
    if (p_rst) begin
      t      = 0;
      m_act  = 16'hFFFF;
      m_shd  = 16'hFFFF;
      m_msk  = 4'hF;
      m_shm  = 4'hF;
      m_pend = 1'b0;
    end else begin
      if (t % FR == FR - 1) begin
        if (m_pend) begin
          m_act = m_shd;
          m_msk = m_shm;
        end
        m_pend = 1'b0;
      end
      if (p_ld) begin
        m_shd  = p_c;
        m_shm  = p_m;
        m_pend = 1'b1;
      end
      t++;
    end
    cnt     = t % RD;
    dig     = (t / RD) % ND;
    e.t     = t;
    e.code  = m_act[dig*4 +: 4];
    e.blank = (cnt < BC);
    e.an    = 4'hF;
    if (!e.blank && m_msk[dig]) e.an[dig] = 1'b0;
    e.frame = (t > 0) && (t % FR == 0);
    e.pend  = m_pend;
    q.push_back(e);
    rst       = r;
    load_i    = ld;
    codes_i   = c;
    en_mask_i = m;
    p_rst     = r;
    p_ld      = ld;
    p_c       = c;
    p_m       = m;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("code_o",    e.t, code_o, e.code);
        chk("an_o",      e.t, an_o,   e.an);
        chk("blank_o",   e.t, {3'b000, blank_o},   {3'b000, e.blank});
        chk("frame_o",   e.t, {3'b000, frame_o},   {3'b000, e.frame});
        chk("pending_o", e.t, {3'b000, pending_o}, {3'b000, e.pend});
      end
    end
  end

  // Cycle gc maps to t = gc-2 until the mid-frame reset at gc=247 (t=245: cnt=5, dig=2).
  initial begin
    logic        r;
    logic        ld;
    logic [15:0] c;
    logic [3:0]  m;
    for (int gc = 0; gc < 300; gc++) begin
      r  = 1'b0;
      ld = 1'b0;
      c  = 16'($urandom);
      m  = 4'($urandom);
      case (gc)
        0, 1: r = 1'b1;
        7:    begin ld = 1'b1; c = 16'hA521; m = 4'hF;    end
        42:   begin ld = 1'b1; c = 16'h8765; m = 4'b0101; end
        102:  begin ld = 1'b1; c = 16'h1111; m = 4'hF;    end
        129:  begin ld = 1'b1; c = 16'h2222; m = 4'hF;    end
        197:  begin ld = 1'b1; c = 16'h3333; m = 4'hF;    end
        202:  begin ld = 1'b1; c = 16'h4444; m = 4'hF;    end
        232:  begin ld = 1'b1; c = 16'h5555; m = 4'hF;    end
        247:  r = 1'b1;
        default: ;
      endcase
      step(r, ld, c, m);
    end
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
